// File: rtl/display_7seg_pkg.sv
// display_7seg_pkg: shared register map, FSM encoding and BCD helpers for display_7seg_controller.
// Rev 1.0
`default_nettype none

package display_7seg_pkg;

   localparam logic [1:0] c_OFF_DATA   = 2'd0;
   localparam logic [1:0] c_OFF_CTRL   = 2'd1;
   localparam logic [1:0] c_OFF_STATUS = 2'd2;
   localparam logic [1:0] c_OFF_SHOWN  = 2'd3;

   localparam int c_CTRL_MODE_BIT = 0;
   localparam int c_CTRL_HOLD_BIT = 1;
   localparam int c_STAT_BUSY_BIT = 0;
   localparam int c_STAT_OVF_BIT  = 1;

   localparam int c_BCD_WIDTH  = 40;
   localparam int c_CONV_ITERS = 32;
   localparam int c_CNT_WIDTH  = 6;
   localparam logic [c_CNT_WIDTH-1:0] c_LAST_ITER = 6'(c_CONV_ITERS - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CONVERT = 2'd1,
      ST_COMMIT  = 2'd2
   } conv_state_t;

   // Double-dabble correction: every BCD digit >= 5 gets +3 before the shift.
   function automatic logic [c_BCD_WIDTH-1:0] bcd_adjust(input logic [c_BCD_WIDTH-1:0] bcd);
      logic [c_BCD_WIDTH-1:0] r;
      r = bcd;
      for (int i = 0; i < c_BCD_WIDTH / 4; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) begin
            r[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
         end
      end
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/display_7seg_controller_bin2bcd_seq.sv
// bin2bcd_seq: iterative 32-bit binary to 10-digit BCD converter, one shift per clock.
// Rev 1.0
`default_nettype none

module bin2bcd_seq
   import display_7seg_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i_start,
   input  logic                   i_abort,
   input  logic [31:0]            i_bin,
   output logic                   o_busy,
   output logic                   o_done,
   output logic [c_BCD_WIDTH-1:0] o_bcd
);

   conv_state_t            r_state;
   conv_state_t            w_state_next;
   logic [31:0]            r_bin;
   logic [c_BCD_WIDTH-1:0] r_bcd;
   logic [c_CNT_WIDTH-1:0] r_count;
   logic [c_BCD_WIDTH+31:0] w_shifted;

   assign w_shifted = {bcd_adjust(r_bcd), r_bin} << 1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // A start always wins, so a retrigger in CONVERT or COMMIT restarts cleanly.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:    w_state_next = ST_IDLE;
         ST_CONVERT: if (r_count == c_LAST_ITER) w_state_next = ST_COMMIT;
         ST_COMMIT:  w_state_next = ST_IDLE;
         default:    w_state_next = ST_IDLE;
      endcase
      if (i_start) begin
         w_state_next = ST_CONVERT;
      end else if (i_abort) begin
         w_state_next = ST_IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bin   <= '0;
         r_bcd   <= '0;
         r_count <= '0;
      end else if (i_start) begin
         r_bin   <= i_bin;
         r_bcd   <= '0;
         r_count <= '0;
      end else if (r_state == ST_CONVERT) begin
         {r_bcd, r_bin} <= w_shifted;
         r_count        <= r_count + 1'b1;
      end
   end

   assign o_busy = (r_state != ST_IDLE);
   assign o_done = (r_state == ST_COMMIT);
   assign o_bcd  = r_bcd;

endmodule

`default_nettype wire

// File: rtl/display_7seg_controller.sv
// display_7seg_controller: bus slave holding a value shown on 8 digits in hex or decimal.
// Optional HOLD freeze enabled by defining DISPLAY_7SEG_HOLD_EN. Rev 1.0
`default_nettype none

module display_7seg_controller
   import display_7seg_pkg::*;
#(
   parameter logic [31:0] BASE_ADDRESS     = 32'hFF20_0000,
   parameter logic [31:0] OVERFLOW_PATTERN = 32'h9999_9999
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [31:0] bus_address,
   input  logic [31:0] bus_write_data,
   input  logic [3:0]  bus_byte_enable,
   input  logic        bus_write_enable,
   input  logic        bus_read_enable,
   output logic [31:0] bus_read_data,
   output logic [31:0] display_data,
   output logic        conversion_busy
);

   logic                   r_mode;
   logic                   r_ovf;
   logic [31:0]            r_data;
   logic                   w_hold;
   logic                   w_sel;
   logic [1:0]             w_off;
   logic                   w_wr_data;
   logic                   w_wr_ctrl;
   logic [31:0]            w_data_next;
   logic                   w_mode_next;
   logic                   w_start;
   logic                   w_abort;
   logic                   w_busy;
   logic                   w_done;
   logic                   w_commit;
   logic                   w_bcd_ovf;
   logic [c_BCD_WIDTH-1:0] w_bcd;
   logic [31:0]            w_rd_value;
   logic                   w_unused;

   assign w_unused  = &{1'b0, bus_address[1:0]};
   assign w_sel     = (bus_address[31:4] == BASE_ADDRESS[31:4]);
   assign w_off     = bus_address[3:2];
   assign w_wr_data = bus_write_enable && w_sel && (w_off == c_OFF_DATA);
   assign w_wr_ctrl = bus_write_enable && w_sel && (w_off == c_OFF_CTRL);

   always_comb begin
      w_data_next = r_data;
      if (w_wr_data) begin
         for (int b = 0; b < 4; b++) begin
            if (bus_byte_enable[b]) w_data_next[8*b +: 8] = bus_write_data[8*b +: 8];
         end
      end
   end

   assign w_mode_next = (w_wr_ctrl && bus_byte_enable[0]) ? bus_write_data[c_CTRL_MODE_BIT] : r_mode;
   assign w_start     = (w_wr_data || w_wr_ctrl) && w_mode_next;
   assign w_abort     = w_wr_ctrl && !w_mode_next && w_busy;
   // A same-edge retrigger or abort supersedes the result of the old conversion.
   assign w_commit    = w_done && !w_start && !w_abort;
   assign w_bcd_ovf   = (w_bcd[c_BCD_WIDTH-1:32] != '0);

`ifdef DISPLAY_7SEG_HOLD_EN
   logic r_hold;
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_hold <= 1'b0;
      end else if (w_wr_ctrl && bus_byte_enable[0]) begin
         r_hold <= bus_write_data[c_CTRL_HOLD_BIT];
      end
   end
   assign w_hold = r_hold;
`else
   assign w_hold = 1'b0;
`endif

   bin2bcd_seq u_bin2bcd (
      .clk     (clock),
      .rst_n   (reset_n),
      .i_start (w_start),
      .i_abort (w_abort),
      .i_bin   (w_data_next),
      .o_busy  (w_busy),
      .o_done  (w_done),
      .o_bcd   (w_bcd)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_data       <= '0;
         r_mode       <= 1'b0;
         r_ovf        <= 1'b0;
         display_data <= '0;
      end else begin
         r_data <= w_data_next;
         r_mode <= w_mode_next;
         if (w_abort) begin
            r_ovf <= 1'b0;
         end else if (w_commit) begin
            r_ovf <= w_bcd_ovf;
         end
         if (!w_hold) begin
            if (!r_mode) begin
               display_data <= r_data;
            end else if (w_commit) begin
               display_data <= w_bcd_ovf ? OVERFLOW_PATTERN : w_bcd[31:0];
            end
         end
      end
   end

   always_comb begin
      w_rd_value = '0;
      if (w_sel) begin
         case (w_off)
            c_OFF_DATA: w_rd_value = r_data;
            c_OFF_CTRL: begin
               w_rd_value[c_CTRL_MODE_BIT] = r_mode;
               w_rd_value[c_CTRL_HOLD_BIT] = w_hold;
            end
            c_OFF_STATUS: begin
               w_rd_value[c_STAT_BUSY_BIT] = w_busy;
               w_rd_value[c_STAT_OVF_BIT]  = r_ovf;
            end
            c_OFF_SHOWN: w_rd_value = display_data;
            default:     w_rd_value = '0;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         bus_read_data <= '0;
      end else if (bus_read_enable) begin
         bus_read_data <= w_rd_value;
      end
   end

   assign conversion_busy = w_busy;

endmodule

`default_nettype wire
